// File: rtl/dp_pkg.sv
// Shared types for the single-bus datapath: opcodes, sequencer states and bus sources.
package dp_pkg;

  localparam int RIDX_W = 5;

  typedef enum logic [2:0] {
    op_add = 3'b000,
    op_sub = 3'b001,
    op_and = 3'b010,
    op_or  = 3'b011,
    op_shl = 3'b100,
    op_shr = 3'b101,
    op_ldi = 3'b110,
    op_mul = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    st_idle,
    st_t1,
    st_t2,
    st_t3,
    st_t4,
    st_wb,
    st_done
  } state_t;

  typedef enum logic [2:0] {
    bus_none,
    bus_rb,
    bus_rc,
    bus_zlo,
    bus_zhi,
    bus_imm
  } bus_src_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for the bus datapath; 2W-bit result so a full product fits.
// The signed multiply exists only when DP_MUL_EN is defined.
module dp_alu
  import dp_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  op_t            op,
  output logic [2*W-1:0] result
);

  localparam int SHW = $clog2(W);
  localparam int W2  = 2 * W;

  logic [SHW-1:0] shamt;
  logic [W-1:0]   low;

  // Only the low log2(W) bits of the operand set the shift distance.
  assign shamt = b[SHW-1:0];

  always_comb begin
    low = '0;
    case (op)
      op_add:  low = a + b;
      op_sub:  low = a - b;
      op_and:  low = a & b;
      op_or:   low = a | b;
      op_shl:  low = a << shamt;
      op_shr:  low = a >> shamt;
      default: low = '0;
    endcase
    result = {{W{1'b0}}, low};
`ifdef DP_MUL_EN
    if (op == op_mul) begin
      result = W2'($signed(a)) * W2'($signed(b));
    end
`endif
  end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus datapath (registers, Y, Z, HI, LO) driven by an internal micro-step sequencer.
// Define DP_MUL_EN to enable the signed MUL opcode; otherwise MUL is rejected as illegal.
module bus_datapath_seq
  import dp_pkg::*;
#(
  parameter int W       = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  op_t               cmd_op,
  input  logic [RIDX_W-1:0] cmd_ra,
  input  logic [RIDX_W-1:0] cmd_rb,
  input  logic [RIDX_W-1:0] cmd_rc,
  input  logic [W-1:0]      cmd_imm,
  output logic              done,
  output logic              err,
  output logic [W-1:0]      bus_out,
  input  logic [RIDX_W-1:0] rd_sel,
  output logic [W-1:0]      rd_data,
  output logic [W-1:0]      hi_out,
  output logic [W-1:0]      lo_out
);

  localparam int NSLOT = 2 ** RIDX_W;
`ifdef DP_MUL_EN
  localparam int ZW = 2 * W;
`else
  localparam int ZW = W;
`endif

  state_t            state_reg, state_next;
  op_t               op_reg;
  logic [RIDX_W-1:0] ra_reg, rb_reg, rc_reg;
  logic [W-1:0]      imm_reg, y_reg, hi_reg, lo_reg;
  logic [ZW-1:0]     z_reg;
  logic              err_reg;
  logic [W-1:0]      regs_reg [NREGS];
  logic [W-1:0]      rf_view [NSLOT];
  logic [NREGS-1:0]  rf_we;
  logic [W-1:0]      zlow, zhigh;
  logic [2*W-1:0]    alu_result;
  bus_src_t          bus_src;
  logic              y_load, z_load, rf_load, lo_load, hi_load;
  logic              cmd_bad;

  function automatic logic idx_ok(input logic [RIDX_W-1:0] idx);
    return int'(idx) < NREGS;
  endfunction

  // Pad the register file to the full index space so out-of-range reads give zero.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_view
      if (gi < NREGS) begin : g_live
        assign rf_view[gi] = regs_reg[gi];
      end else begin : g_pad
        assign rf_view[gi] = '0;
      end
    end

    for (gi = 0; gi < NREGS; gi++) begin : g_we
      if (gi == 0 && R0_ZERO != 0) begin : g_r0
        assign rf_we[gi] = 1'b0;
      end else begin : g_rn
        assign rf_we[gi] = rf_load && (ra_reg == RIDX_W'(gi));
      end
    end
  endgenerate

  assign zlow = z_reg[W-1:0];
`ifdef DP_MUL_EN
  assign zhigh = z_reg[ZW-1:W];
`else
  logic unused_alu_hi;
  assign zhigh         = '0;
  assign unused_alu_hi = ^alu_result[2*W-1:W];
`endif

  dp_alu #(.W(W)) u_alu (
    .a      (y_reg),
    .b      (bus_out),
    .op     (op_reg),
    .result (alu_result)
  );

  // Only fields the opcode actually uses are range-checked.
  always_comb begin
    cmd_bad = 1'b0;
    case (cmd_op)
      op_ldi: cmd_bad = !idx_ok(cmd_ra);
      op_mul: begin
`ifdef DP_MUL_EN
        cmd_bad = !idx_ok(cmd_rb) || !idx_ok(cmd_rc);
`else
        cmd_bad = 1'b1;
`endif
      end
      default: cmd_bad = !idx_ok(cmd_ra) || !idx_ok(cmd_rb) || !idx_ok(cmd_rc);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    bus_src    = bus_none;
    y_load     = 1'b0;
    z_load     = 1'b0;
    rf_load    = 1'b0;
    lo_load    = 1'b0;
    hi_load    = 1'b0;
    case (state_reg)
      st_idle: begin
        if (cmd_valid) begin
          state_next = (cmd_bad || cmd_op == op_ldi) ? st_wb : st_t1;
        end
      end
      st_t1: begin
        bus_src    = bus_rb;
        y_load     = 1'b1;
        state_next = st_t2;
      end
      st_t2: begin
        bus_src    = bus_rc;
        z_load     = 1'b1;
        state_next = st_t3;
      end
      st_t3: begin
        bus_src = bus_zlo;
        if (op_reg == op_mul) begin
          lo_load    = 1'b1;
          state_next = st_t4;
        end else begin
          rf_load    = 1'b1;
          state_next = st_done;
        end
      end
      st_t4: begin
        bus_src    = bus_zhi;
        hi_load    = 1'b1;
        state_next = st_done;
      end
      st_wb: begin
        // A rejected command idles here for one cycle without touching anything.
        if (!err_reg) begin
          bus_src = bus_imm;
          rf_load = 1'b1;
        end
        state_next = st_done;
      end
      st_done: state_next = st_idle;
      default: state_next = st_idle;
    endcase
  end

  always_comb begin
    bus_out = '0;
    case (bus_src)
      bus_rb:  bus_out = rf_view[rb_reg];
      bus_rc:  bus_out = rf_view[rc_reg];
      bus_zlo: bus_out = zlow;
      bus_zhi: bus_out = zhigh;
      bus_imm: bus_out = imm_reg;
      default: bus_out = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_reg <= st_idle;
      op_reg    <= op_add;
      ra_reg    <= '0;
      rb_reg    <= '0;
      rc_reg    <= '0;
      imm_reg   <= '0;
      err_reg   <= 1'b0;
      y_reg     <= '0;
      z_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (cmd_valid && cmd_ready) begin
        op_reg  <= cmd_op;
        ra_reg  <= cmd_ra;
        rb_reg  <= cmd_rb;
        rc_reg  <= cmd_rc;
        imm_reg <= cmd_imm;
        err_reg <= cmd_bad;
      end
      if (y_load)  y_reg  <= bus_out;
      if (z_load)  z_reg  <= alu_result[ZW-1:0];
      if (lo_load) lo_reg <= bus_out;
      if (hi_load) hi_reg <= bus_out;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (rf_we[i]) regs_reg[i] <= bus_out;
      end
    end
  end

  assign cmd_ready = (state_reg == st_idle);
  assign done      = (state_reg == st_done);
  assign err       = done && err_reg;
  assign rd_data   = rf_view[rd_sel];
  assign hi_out    = hi_reg;
  assign lo_out    = lo_reg;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed scoreboard bench for bus_datapath_seq (W=32, NREGS=12); MUL expectations follow DP_MUL_EN.
module tb_bus_datapath_seq;
  import dp_pkg::*;

  localparam int W  = 32;
  localparam int NR = 12;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  op_t           cmd_op = op_add;
  logic [4:0]    cmd_ra = '0, cmd_rb = '0, cmd_rc = '0;
  logic [W-1:0]  cmd_imm = '0;
  logic          done, err;
  logic [W-1:0]  bus_out;
  logic [4:0]    rd_sel = '0;
  logic [W-1:0]  rd_data, hi_out, lo_out;

  bus_datapath_seq #(.W(W), .NREGS(NR), .R0_ZERO(1)) dut (
    .clock     (clock),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_rc    (cmd_rc),
    .cmd_imm   (cmd_imm),
    .done      (done),
    .err       (err),
    .bus_out   (bus_out),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic        err;
    int          lat;
    int          ra;
    logic [31:0] val;
    logic        is_mul;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [NR];
  logic [31:0] m_hi, m_lo;
  int          total = 0;
  int          bad = 0;
  int          acc_cyc = 0;
  int          prev_acc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_alu(input op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      op_add:  return a + b;
      op_sub:  return a - b;
      op_and:  return a & b;
      op_or:   return a | b;
      op_shl:  return a << b[4:0];
      op_shr:  return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic scan_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      rd_sel = 5'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), rd_data, m_regs[i]);
    end
    check({tag, "_hi"}, hi_out, m_hi);
    check({tag, "_lo"}, lo_out, m_lo);
  endtask

  task automatic accept(input op_t op, input int ra, input int rb, input int rc,
                        input logic [31:0] imm, input logic hold);
    int n = 0;
    @(negedge clock);
    cmd_op = op; cmd_ra = 5'(ra); cmd_rb = 5'(rb); cmd_rc = 5'(rc); cmd_imm = imm;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check("accept_timeout", 64'(n), 64'(0));
    @(posedge clock);
    #1;
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Predict the outcome from the bench's own model, queue it, then hand the command over.
  task automatic issue(input string tag, input op_t op, input int ra, input int rb, input int rc,
                       input logic [31:0] imm, input logic hold);
    exp_t   e;
    logic   is_bad;
    longint prod;
    int     sa, sbv;
    e.tag = tag; e.ra = ra; e.is_mul = (op == op_mul); e.err = 1'b0; e.val = '0; e.lat = 3;
    if (op == op_ldi) is_bad = (ra >= NR);
    else if (op == op_mul) begin
`ifdef DP_MUL_EN
      is_bad = (rb >= NR) || (rc >= NR);
`else
      is_bad = 1'b1;
`endif
    end else is_bad = (ra >= NR) || (rb >= NR) || (rc >= NR);
    if (is_bad) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (op == op_ldi) begin
      e.lat = 1;
      if (ra != 0) m_regs[ra] = imm;
    end else if (op == op_mul) begin
      e.lat = 4;
      sa = m_regs[rb];
      sbv = m_regs[rc];
      prod = longint'(sa) * longint'(sbv);
      m_hi = prod[63:32];
      m_lo = prod[31:0];
    end else begin
      e.lat = 3;
      if (ra != 0) m_regs[ra] = model_alu(op, m_regs[rb], m_regs[rc]);
    end
    if (ra < NR) e.val = m_regs[ra];
    e.hi = m_hi;
    e.lo = m_lo;
    sb.push_back(e);
    accept(op, ra, rb, rc, imm, hold);
  endtask

  task automatic finish_cmd();
    exp_t e;
    int   n = 0;
    logic rdy_seen = 1'b0;
    do begin
      @(negedge clock);
      n++;
      if (!done) rdy_seen |= cmd_ready;
    end while (!done && n < 20);
    e = sb.pop_front();
    check({e.tag, "_done_cycle"}, 64'(cyc - acc_cyc), 64'(e.lat));
    check({e.tag, "_err"}, 64'(err), 64'(e.err));
    check({e.tag, "_busy_ready"}, 64'(rdy_seen), 64'(0));
    check({e.tag, "_bus_idle"}, bus_out, 64'(0));
    if (!e.err && e.ra < NR) begin
      rd_sel = 5'(e.ra);
      #1;
      check({e.tag, "_rd"}, rd_data, e.val);
    end
    if (e.is_mul || e.err) begin
      check({e.tag, "_hi"}, hi_out, e.hi);
      check({e.tag, "_lo"}, lo_out, e.lo);
    end
    $display("[%0t] cmd %s retired: cycles=%0d err=%0b", $time, e.tag, cyc - acc_cyc, err);
  endtask

  task automatic run(input string tag, input op_t op, input int ra, input int rb, input int rc,
                     input logic [31:0] imm);
    issue(tag, op, ra, rb, rc, imm, 1'b0);
    finish_cmd();
  endtask

  initial begin
    int   seen;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_hi = '0;
    m_lo = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 64'(cmd_ready), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_bus", bus_out, 64'(0));
    clear = 1'b1;
    @(negedge clock);
    scan_regs("rst");
    rd_sel = 5'd20;
    #1;
    check("rd_out_of_range", rd_data, 64'(0));

    // Basic LDI / ADD
    run("ldi_r1", op_ldi, 1, 0, 0, 32'd5);
    run("ldi_r2", op_ldi, 2, 0, 0, 32'd7);
    run("add_r3", op_add, 3, 1, 2, 32'd0);

    // Wrap-around and SUB
    run("ldi_r1_ff", op_ldi, 1, 0, 0, 32'hFFFF_FFFF);
    run("ldi_r2_1", op_ldi, 2, 0, 0, 32'd1);
    run("add_wrap", op_add, 4, 1, 2, 32'd0);
    run("sub_r5", op_sub, 5, 2, 1, 32'd0);

    // Aliased destination and shift amount truncation
    run("ldi_r1_81", op_ldi, 1, 0, 0, 32'h8000_0001);
    run("shr_alias", op_shr, 1, 1, 2, 32'd0);
    run("ldi_r6_33", op_ldi, 6, 0, 0, 32'd33);
    run("ldi_r8_3", op_ldi, 8, 0, 0, 32'd3);
    run("shl_33", op_shl, 7, 8, 6, 32'd0);
    run("or_r9", op_or, 9, 1, 8, 32'd0);
    run("and_r10", op_and, 10, 9, 6, 32'd0);

    // R0 discards writes without error
    run("ldi_r0", op_ldi, 0, 0, 0, 32'h55);
    run("add_r0", op_add, 0, 1, 2, 32'd0);

    // Out-of-range indices are rejected with no side effects
    run("add_ra12", op_add, 12, 1, 2, 32'd0);
    run("sub_rc31", op_sub, 3, 1, 31, 32'd0);
    run("ldi_ra15", op_ldi, 15, 0, 0, 32'h1234);
    scan_regs("range");

    // Busy: second command held valid is taken only after DONE
    issue("busy_add", op_add, 10, 1, 2, 32'd0, 1'b1);
    finish_cmd();
    issue("busy_ldi", op_ldi, 11, 0, 0, 32'hABCD, 1'b0);
    check("busy_accept_gap", 64'(acc_cyc - prev_acc), 64'(5));
    finish_cmd();

    // Multiply (or illegal opcode when the multiplier is absent)
    run("ldi_r1_10k", op_ldi, 1, 0, 0, 32'h0001_0000);
    run("ldi_r2_10k", op_ldi, 2, 0, 0, 32'h0001_0000);
    run("mul_pos", op_mul, 3, 1, 2, 32'd0);
    run("ldi_r4_m1", op_ldi, 4, 0, 0, 32'hFFFF_FFFF);
    run("ldi_r5_2", op_ldi, 5, 0, 0, 32'd2);
    run("mul_neg", op_mul, 3, 4, 5, 32'd0);
    scan_regs("mul");

    // Reset during T2 aborts the command
    accept(op_add, 3, 1, 2, 32'd0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
    clear = 1'b1;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clock);
    check("abort_ready", 64'(cmd_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) seen++;
      @(negedge clock);
    end
    check("abort_no_done", 64'(seen), 64'(0));
    scan_regs("abort");
    $display("[%0t] reset abort sequence complete", $time);

    run("post_rst_ldi", op_ldi, 2, 0, 0, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_datapath_seq.md
# bus_datapath_seq

Parametrised single-bus datapath with a built-in micro-step sequencer. It holds NREGS general registers plus Y, Z (Zhigh/Zlow), HI and LO on one shared W-bit bus. It accepts one register-to-register command at a time over a valid/ready handshake and runs it as timed bus transfers (operand→Y, ALU→Z, Z→destination). It is the next-generation core datapath, replacing hand-driven per-register enables with an internal controller.

## Interface
Parameters:
- W, 32, data/bus width (≥8)
- NREGS, 16, number of general registers (2..32)
- R0_ZERO, 1, 1 = R0 reads as zero and ignores writes

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  3  opcode (dp_pkg::op_t)
- cmd_ra / cmd_rb / cmd_rc  in  5 each  destination / operand A / operand B indices
- cmd_imm  in  W  immediate for LDI
- done  out  1  one-cycle pulse: command retired
- err  out  1  one-cycle pulse with done: command rejected, no state changed
- bus_out  out  W  current bus value; 0 when no driver
- rd_sel  in  5  debug read index
- rd_data  out  W  combinational R[rd_sel]; 0 if out of range
- hi_out / lo_out  out  W  HI and LO contents

## Operation
- Opcodes:
  - ADD 000, SUB 001, AND 010, OR 011: R[ra] ← R[rb] op R[rc].
  - SHL 100, SHR 101 (logical): shift amount = R[rc][$clog2(W)-1:0].
  - LDI 110: R[ra] ← cmd_imm.
  - MUL 111: see Configuration.
- Arithmetic is modulo 2^W; no flags.
- States:
  - IDLE: accept when cmd_valid && cmd_ready; latch op and indices. LDI→WB; ALU ops→T1.
  - T1: bus=R[rb]; Y←bus.
  - T2: bus=R[rc]; Z←ALU(Y, bus).
  - T3: bus=Zlow; R[ra]←bus (MUL: LO←bus).
  - T4 (MUL only): bus=Zhigh; HI←bus.
  - WB (LDI): bus=imm; R[ra]←bus.
  - DONE: done=1; go to IDLE.
- Bus driver: at most one source is selected per cycle, from the state. In IDLE and DONE no source drives and bus_out=0.
- Index ≥ NREGS on any used field:
  - Command goes straight to DONE with err=1.
  - No register, Y, Z, HI or LO changes.
- Write to R0 when R0_ZERO=1: the write is dropped and done=1 without err.
- ra equal to rb or rc is legal: operands are read before writeback.
- Commands while busy are not accepted (cmd_ready=0); the issuer must hold cmd_valid.

## Timing
- Reset (clear=0 at an edge):
  - State goes to IDLE; all registers, Y, Z, HI, LO are zeroed.
  - done=0, err=0, cmd_ready=1 from the next cycle.
  - bus_out=0.
- Reset mid-command aborts it: no done pulse and no partial writeback after the reset edge.
- Acceptance edge k:
  - ALU op: R[ra] written at edge k+3; done high in cycle k+3..k+4.
  - LDI: written at edge k+1; done in cycle k+1..k+2.
  - MUL: done in cycle k+4..k+5.
  - Error: done/err in cycle k+1..k+2.
- Throughput: one command per 5 cycles for ALU ops, back-to-back (cmd_ready returns the cycle after DONE).
- rd_data, hi_out, lo_out show post-edge values with no extra delay.

## Configuration
- DP_MUL_EN defined:
  - MUL is a signed W×W multiply; Z holds the 2W-bit product.
  - T3 loads LO, T4 loads HI; R[ra] is untouched.
- DP_MUL_EN undefined:
  - MUL behaves as an illegal opcode: done+err one cycle after acceptance, no state change.
  - Z is W bits; Zhigh is absent and reads 0.

## Structure
- dp_pkg:
  - op_t opcode enum and state_t enum.
  - Index width constant RIDX_W=5.
- Sub-module dp_alu: combinational, parametrised on W. Inputs a, b, op; 2W-bit result, with the MUL path under DP_MUL_EN.
- The sequencer, register file, bus mux, Y and Z stay in bus_datapath_seq.

## Test plan
- Reset then ADD: LDI R1←5, LDI R2←7, ADD R3,R1,R2 → rd_data(R3)=12; done exactly 3 cycles after ADD acceptance.
- Wrap and SUB (W=32): R1=0xFFFFFFFF, R2=1, ADD R4,R1,R2 → 0; SUB R5,R2,R1 → 2.
- Alias and shift: R1=0x80000001, R2=1, SHR R1,R1,R2 → R1=0x40000000; SHL by R[rc]=33 uses amount 1.
- R0 and range: LDI R0←0x55 → R0 stays 0 with done, no err. NREGS=12, ADD R12,R1,R2 → err pulse, all registers unchanged.
- Busy and reset: cmd_valid held through a 5-cycle ADD → second command accepted only in the cycle after DONE. clear=0 during T2 → no done, R[ra] unchanged, cmd_ready=1 next cycle.
- MUL (DP_MUL_EN): R1=0x10000, R2=0x10000 → HI=1, LO=0. Without DP_MUL_EN: err pulse, HI/LO stay 0.
